quantize_stream: RTL and testbench
==================================

QUANTIZE_STREAM -- requirements
Module: quantize_stream

Interface
REQ-001 The block SHALL have parameter COEF_W, default 12, signed DCT coefficient width.
REQ-002 The block SHALL have parameter OUT_W, default 10, signed quantized output width (OUT_W <= COEF_W).
REQ-003 The block SHALL have parameter LANES, default 8, coefficients per beat (one 8x8 row; only 8 supported, elaboration error otherwise).
REQ-004 The block SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port flush  input  1  synchronous clear of row counter and pipeline.
REQ-007 The block SHALL have port in_valid  input  1  input beat valid.
REQ-008 The block SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-009 The block SHALL have port in_coeffs  input  LANES*COEF_W  row coefficients, lane k at bits [k*COEF_W +: COEF_W].
REQ-010 The block SHALL have port is_luminance  input  1  table select (1 luma, 0 chroma), sampled on row-0 beats only.
REQ-011 The block SHALL have port quantize_off  input  1  bypass, sampled per beat.
REQ-012 The block SHALL have port out_valid  output  1  output beat valid.
REQ-013 The block SHALL have port out_ready  input  1  downstream accept.
REQ-014 The block SHALL have port out_coeffs  output  LANES*OUT_W  quantized row, lane k at bits [k*OUT_W +: OUT_W].
REQ-015 The block SHALL have port out_row  output  3  row index of out_coeffs within the block.
REQ-016 The block SHALL have port out_last  output  1  high when out_row == 7.

Function
REQ-017 Row counter SHALL start at 0, increment per accepted beat, wrap 7->0; each beat tagged with the pre-increment value.
REQ-018 is_luminance SHALL be latched on row-0 accept and used for rows 0-7 of that block; changes mid-block have no effect.
REQ-019 Quantize mode: q = sign(c) * ((|c| * R[row][k] + 0x8000) >> 16), R = round(65536/Q), Q from JPEG Annex K luma/chroma tables.
REQ-020 |c| SHALL be computed at COEF_W+1 bits so the most negative coefficient (-2^(COEF_W-1)) is exact.
REQ-021 Result SHALL saturate to +/-(2^(OUT_W-1)-1); -2^(OUT_W-1) is never produced.
REQ-022 Bypass mode (quantize_off=1): out = c saturated per REQ-021, same latency.
REQ-023 Pipeline SHALL be 2 stages (multiply, round/saturate); accepted beat appears on out_valid 2 cycles later when out_ready held high.
REQ-024 Full throughput: one beat per cycle sustained with out_ready=1.
REQ-025 in_ready SHALL equal !(stage-2 valid) || out_ready, with each stage advancing when next stage is empty or advancing.
REQ-026 While out_valid && !out_ready, out_coeffs, out_row, out_last SHALL hold stable.
REQ-027 flush SHALL clear row counter and both stage valids next edge; a beat presented with flush is dropped; in_ready is 0 during flush.

Reset
REQ-028 On reset_n low: out_valid=0, out_coeffs=0, out_row=0, out_last=0, row counter=0, latched mode=luminance, stage valids=0.
REQ-029 in_ready SHALL be 0 while reset_n low, 1 from first edge after release.
REQ-030 Reset mid-block SHALL discard in-flight beats; next accepted beat is row 0.

Structure
REQ-031 Package quantize_pkg SHALL hold luma/chroma Q tables, 16-bit reciprocal tables R, and saturation helper function.
REQ-032 One sub-module quant_lane (one coefficient: abs, multiply, round, sign, saturate, bypass) SHALL be instantiated LANES times.

Verification
REQ-033 Luma row 0, lane 0, c=100 -> 6; c=-100 -> -6 (Q=16, R=4096).
REQ-034 Chroma row 0, lane 0, c=100 -> 6 (Q=17, R=3855); lane 1 c=100 -> 6 (Q=18).
REQ-035 quantize_off=1, c=2047 -> 511, c=-2048 -> -511, c=-5 -> -5.
REQ-036 9 back-to-back beats, out_ready=1 -> out_row 0..7,0; out_last only on 8th; first out_valid 2 cycles after first accept.
REQ-037 out_ready low 3 cycles mid-stream -> out_coeffs stable, in_ready low after 2 stalled beats, no loss/duplication on release.
REQ-038 reset_n pulsed after row 4, and flush after row 2 -> no stale out_valid; next beat reported as out_row 0.

Source files
------------

// File: rtl/quantize_pkg.sv
// Shared constants for the JPEG row quantizer: Annex K quantizer tables, their
// 16-bit reciprocals (built at elaboration) and the output saturation helper.
package quantize_pkg;

    typedef logic [0:63][7:0]  qtab_t;
    typedef logic [0:63][15:0] rtab_t;

    localparam qtab_t LUMA_Q = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    localparam qtab_t CHROMA_Q = '{
        8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
        8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
    };

    // Rounded 65536/Q; every table entry is >= 10 so the result fits 16 bits.
    function automatic rtab_t make_recip(input qtab_t q);
        rtab_t r;
        for (int i = 0; i < 64; i++) begin
            r[i] = 16'((32'd65536 + 32'(q[i] >> 1)) / 32'(q[i]));
        end
        return r;
    endfunction

    localparam rtab_t LUMA_R   = make_recip(LUMA_Q);
    localparam rtab_t CHROMA_R = make_recip(CHROMA_Q);

    // Clamp a magnitude to the largest positive value of an out_w-bit signed word.
    function automatic logic [31:0] sat_mag(input logic [31:0] mag, input int out_w);
        logic [31:0] lim;
        lim = (32'd1 << (out_w - 1)) - 32'd1;
        return (mag > lim) ? lim : mag;
    endfunction

endpackage

// File: rtl/quantize_stream_if.sv
// Row stream bundle for quantize_stream: input beat channel, output beat channel, flush.
// A beat moves on a rising edge where valid && ready; valid holds with stable data until then.
interface quantize_stream_if #(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 10,
    parameter int LANES  = 8
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*COEF_W-1:0]  in_coeffs;
    logic                     is_luminance;
    logic                     quantize_off;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_coeffs;
    logic [2:0]               out_row;
    logic                     out_last;

    modport master (
        output flush, in_valid, in_coeffs, is_luminance, quantize_off, out_ready,
        input  in_ready, out_valid, out_coeffs, out_row, out_last
    );

    modport slave (
        input  flush, in_valid, in_coeffs, is_luminance, quantize_off, out_ready,
        output in_ready, out_valid, out_coeffs, out_row, out_last
    );
endinterface

// File: rtl/quant_lane.sv
// One coefficient lane: |c| * reciprocal in stage 1, round/saturate/re-sign in stage 2.
// Bypass carries |c| through the same two registers so latency never changes.
module quant_lane
    import quantize_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en1_i,
    input  logic              en2_i,
    input  logic [COEF_W-1:0] coeff_i,
    input  logic [15:0]       recip_i,
    input  logic              bypass_i,
    output logic [OUT_W-1:0]  q_o
);
    localparam int AW = COEF_W + 1;
    localparam int PW = AW + 16;

    logic [AW-1:0]    c_ext;
    logic [AW-1:0]    abs_d, abs_q;
    logic [PW-1:0]    prod_d, prod_q;
    logic             neg_q, byp_q;
    logic [PW:0]      rounded;
    logic [31:0]      mag, sat;
    logic [OUT_W-1:0] q_d, q_q;

    // One extra bit keeps the magnitude of the most negative input exact.
    assign c_ext  = {coeff_i[COEF_W-1], coeff_i};
    assign abs_d  = c_ext[AW-1] ? (~c_ext + AW'(1)) : c_ext;
    assign prod_d = PW'(abs_d) * PW'(recip_i);

    assign rounded = {1'b0, prod_q} + (PW+1)'(32'h8000);
    assign mag     = byp_q ? 32'(abs_q) : 32'(rounded >> 16);
    assign sat     = sat_mag(mag, OUT_W);
    assign q_d     = neg_q ? OUT_W'(32'd0 - sat) : OUT_W'(sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_q  <= '0;
            prod_q <= '0;
            neg_q  <= 1'b0;
            byp_q  <= 1'b0;
            q_q    <= '0;
        end else begin
            if (en1_i) begin
                abs_q  <= abs_d;
                prod_q <= prod_d;
                neg_q  <= coeff_i[COEF_W-1];
                byp_q  <= bypass_i;
            end
            if (en2_i) begin
                q_q <= q_d;
            end
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/quantize_stream.sv
// Streams 8x8 DCT blocks one row per beat through eight quant_lane instances,
// tracking row index and the luma/chroma table choice latched on each block's row 0.
module quantize_stream
    import quantize_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 10,
    parameter int LANES  = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*COEF_W-1:0] in_coeffs,
    input  logic                    is_luminance,
    input  logic                    quantize_off,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_coeffs,
    output logic [2:0]              out_row,
    output logic                    out_last
);
    if (LANES != 8) begin : g_lanes_chk
        $error("quantize_stream supports LANES == 8 only");
    end
    if (OUT_W > COEF_W) begin : g_width_chk
        $error("quantize_stream requires OUT_W <= COEF_W");
    end

    logic       alive_q;
    logic [2:0] row_d, row_q;
    logic       luma_d, luma_q;
    logic       v1_d, v1_q, v2_d, v2_q;
    logic [2:0] row1_d, row1_q, row2_d, row2_q;
    logic       adv2, accept, cur_luma, en2;

    // Stage 1 only moves when stage 2 is draining, so both stages advance in lockstep.
    assign adv2     = !v2_q || out_ready;
    assign in_ready = alive_q && !flush && adv2;
    assign accept   = in_valid && in_ready;
    assign en2      = adv2 && v1_q && !flush;
    assign cur_luma = (row_q == 3'd0) ? is_luminance : luma_q;

    always_comb begin
        row_d  = row_q;
        luma_d = luma_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        row1_d = row1_q;
        row2_d = row2_q;
        if (flush) begin
            row_d = 3'd0;
            v1_d  = 1'b0;
            v2_d  = 1'b0;
        end else if (adv2) begin
            v2_d = v1_q;
            v1_d = accept;
            if (v1_q) begin
                row2_d = row1_q;
            end
            if (accept) begin
                row1_d = row_q;
                row_d  = row_q + 3'd1;
                if (row_q == 3'd0) begin
                    luma_d = is_luminance;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alive_q <= 1'b0;
            row_q   <= 3'd0;
            luma_q  <= 1'b1;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            row1_q  <= 3'd0;
            row2_q  <= 3'd0;
        end else begin
            alive_q <= 1'b1;
            row_q   <= row_d;
            luma_q  <= luma_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [5:0]  idx;
        logic [15:0] recip;
        assign idx   = {row_q, 3'(k)};
        assign recip = cur_luma ? LUMA_R[idx] : CHROMA_R[idx];

        quant_lane #(
            .COEF_W (COEF_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk      (clock),
            .rst_n    (reset_n),
            .en1_i    (accept),
            .en2_i    (en2),
            .coeff_i  (in_coeffs[k*COEF_W +: COEF_W]),
            .recip_i  (recip),
            .bypass_i (quantize_off),
            .q_o      (out_coeffs[k*OUT_W +: OUT_W])
        );
    end

    assign out_valid = v2_q;
    assign out_row   = row2_q;
    assign out_last  = (row2_q == 3'd7);
endmodule

// File: tb/tb_quantize_stream.sv
// Randomized and directed bench for quantize_stream against a plain-arithmetic
// model of the JPEG quantizer with an expected-row scoreboard.
module tb_quantize_stream;
    localparam int COEF_W = 12;
    localparam int OUT_W  = 10;
    localparam int LANES  = 8;
    localparam int DW     = LANES * OUT_W;
    localparam int W      = 3 + DW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    quantize_stream_if #(.COEF_W(COEF_W), .OUT_W(OUT_W), .LANES(LANES)) bus ();

    quantize_stream #(.COEF_W(COEF_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (bus.flush),
        .in_valid     (bus.in_valid),
        .in_ready     (bus.in_ready),
        .in_coeffs    (bus.in_coeffs),
        .is_luminance (bus.is_luminance),
        .quantize_off (bus.quantize_off),
        .out_valid    (bus.out_valid),
        .out_ready    (bus.out_ready),
        .out_coeffs   (bus.out_coeffs),
        .out_row      (bus.out_row),
        .out_last     (bus.out_last)
    );

    // ---------------- reference model ----------------
    int luma_t[64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,    12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,    14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,  24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
    int chroma_t[64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,  18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,  47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,  99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,  99, 99, 99, 99, 99, 99, 99, 99};

    function automatic logic [DW-1:0] model_row(input logic [LANES*COEF_W-1:0] cf,
                                                input int row, input bit luma, input bit off);
        logic [DW-1:0] r;
        int lim;
        lim = (1 << (OUT_W - 1)) - 1;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            int c, a, m, qv, rr;
            c = $signed(cf[k*COEF_W +: COEF_W]);
            a = (c < 0) ? -c : c;
            if (off) begin
                m = a;
            end else begin
                qv = luma ? luma_t[row*8 + k] : chroma_t[row*8 + k];
                rr = (131072 / qv + 1) / 2;
                m  = (a * rr + 32768) / 65536;
            end
            if (m > lim) m = lim;
            r[k*OUT_W +: OUT_W] = OUT_W'((c < 0) ? -m : m);
        end
        return r;
    endfunction

    // ---------------- scoreboard state ----------------
    logic [W-1:0]  exp_q[$];
    int            acc_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            row_m = 0;
    bit            luma_m = 1'b1;
    bit            lat_chk = 1'b0;
    bit            accepted = 1'b0;
    int            n_out = 0;
    int            n_acc = 0;
    logic [DW-1:0] last_out;
    logic [2:0]    last_row;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        row_m = 0;
    endtask

    task automatic observe();
        logic [W-1:0] f;
        accepted = 1'b0;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                f = exp_q[0];
                check("out_data", {bus.out_row, bus.out_coeffs}, f);
                check("out_last", bus.out_last, (f[W-1 -: 3] == 3'd7));
                if (bus.out_ready) begin
                    if (lat_chk) check("latency", cyc - acc_q[0], 2);
                    last_out = bus.out_coeffs;
                    last_row = bus.out_row;
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    n_out++;
                end
            end
        end
        if (bus.flush) begin
            clear_model();
        end else if (bus.in_valid && bus.in_ready) begin
            if (row_m == 0) luma_m = bus.is_luminance;
            exp_q.push_back({3'(row_m), model_row(bus.in_coeffs, row_m, luma_m, bus.quantize_off)});
            acc_q.push_back(cyc);
            row_m = (row_m + 1) % 8;
            accepted = 1'b1;
            n_acc++;
        end
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        #1;
        observe();
        @(negedge clock);
    endtask

    function automatic logic [LANES*COEF_W-1:0] rand_cf();
        logic [LANES*COEF_W-1:0] cf;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 9))
                0:       cf[k*COEF_W +: COEF_W] = 12'h800;
                1:       cf[k*COEF_W +: COEF_W] = 12'h7FF;
                default: cf[k*COEF_W +: COEF_W] = 12'($urandom_range(0, 4095));
            endcase
        end
        return cf;
    endfunction

    task automatic send(input logic [LANES*COEF_W-1:0] cf, input bit luma, input bit off);
        int n;
        n = 0;
        bus.in_valid     = 1'b1;
        bus.in_coeffs    = cf;
        bus.is_luminance = luma;
        bus.quantize_off = off;
        do begin
            tick();
            n++;
        end while (!accepted && n < 20);
        if (!accepted) check("accept_timeout", accepted, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 20) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic flush_pulse();
        bus.in_valid  = 1'b1;
        bus.in_coeffs = rand_cf();
        bus.flush     = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("flush_out_valid", bus.out_valid, 1'b0);
    endtask

    task automatic row0_beat(input logic [LANES*COEF_W-1:0] cf, input bit luma, input bit off);
        flush_pulse();
        send(cf, luma, off);
        drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [LANES*COEF_W-1:0] cf;
        int n0, a0;
        bit hold;

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_coeffs = '0;
        bus.is_luminance = 1'b1; bus.quantize_off = 1'b0; bus.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_out_valid",  bus.out_valid, 1'b0);
        check("rst_out_coeffs", bus.out_coeffs, '0);
        check("rst_out_row",    bus.out_row, 3'd0);
        check("rst_out_last",   bus.out_last, 1'b0);
        check("rst_in_ready",   bus.in_ready, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", bus.in_ready, 1'b0);
        @(negedge clock);
        #1;
        check("in_ready_after_edge", bus.in_ready, 1'b1);
        @(negedge clock);

        // Known-value rows, each forced to row 0 by a flush.
        cf = rand_cf(); cf[0 +: COEF_W] = 12'd100;
        row0_beat(cf, 1'b1, 1'b0);
        check("luma_pos100", last_out[0 +: OUT_W], 10'd6);
        cf = rand_cf(); cf[0 +: COEF_W] = 12'hF9C;
        row0_beat(cf, 1'b1, 1'b0);
        check("luma_neg100", last_out[0 +: OUT_W], 10'h3FA);
        cf = rand_cf(); cf[0 +: COEF_W] = 12'd100; cf[COEF_W +: COEF_W] = 12'd100;
        row0_beat(cf, 1'b0, 1'b0);
        check("chroma_l0", last_out[0 +: OUT_W], 10'd6);
        check("chroma_l1", last_out[OUT_W +: OUT_W], 10'd6);
        cf = rand_cf(); cf[0 +: COEF_W] = 12'h7FF; cf[COEF_W +: COEF_W] = 12'h800;
        cf[2*COEF_W +: COEF_W] = 12'hFFB;
        row0_beat(cf, 1'b1, 1'b1);
        check("bypass_max", last_out[0 +: OUT_W], 10'd511);
        check("bypass_min", last_out[OUT_W +: OUT_W], 10'h201);
        check("bypass_m5",  last_out[2*OUT_W +: OUT_W], 10'h3FB);

        // Nine back-to-back beats with fixed two-cycle latency.
        flush_pulse();
        n0 = n_out;
        lat_chk = 1'b1;
        for (int i = 0; i < 9; i++) send(rand_cf(), 1'($urandom_range(0, 1)), 1'b0);
        drain();
        lat_chk = 1'b0;
        check("burst_count", n_out - n0, 9);
        check("burst_last_row", last_row, 3'd0);

        // Three-cycle downstream stall in the middle of a stream.
        n0 = n_out; a0 = n_acc;
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || accepted) bus.in_coeffs = rand_cf();
            bus.in_valid  = 1'b1;
            bus.out_ready = !(i >= 5 && i < 8);
            if (i >= 5 && i < 8) begin
                #1;
                check("stall_in_ready", bus.in_ready, 1'b0);
            end
            tick();
        end
        drain();
        check("stall_count", n_out - n0, n_acc - a0);

        // Reset after row 4 of a block.
        flush_pulse();
        for (int i = 0; i < 5; i++) send(rand_cf(), 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        clear_model();
        luma_m = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        send(rand_cf(), 1'b0, 1'b0);
        drain();
        check("midrst_row0", last_row, 3'd0);

        // Flush after row 2 of a block.
        for (int i = 0; i < 3; i++) send(rand_cf(), 1'b1, 1'b0);
        flush_pulse();
        send(rand_cf(), 1'b1, 1'b0);
        drain();
        check("flush_row0", last_row, 3'd0);

        // Random traffic with backpressure, bypass, table changes and flushes.
        for (int i = 0; i < 600; i++) begin
            hold = bus.in_valid && !accepted && !bus.flush;
            if (!hold) begin
                bus.in_coeffs    = rand_cf();
                bus.is_luminance = 1'($urandom_range(0, 1));
                bus.quantize_off = ($urandom_range(0, 3) == 0);
            end
            bus.in_valid  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
